// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program-counter sequencer with fetch handshake and conditional jumps
module pc_sequencer #(
    parameter int                    DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] RESET_ADDR = '0,
    parameter int                    CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_start,
    input  logic                  i_halt,
    input  logic                  i_fetch_ack,
    input  logic                  i_done,
    input  logic                  i_jump_valid,
    input  logic [DATA_WIDTH-1:0] i_operand0,
    input  logic [DATA_WIDTH-1:0] i_operand1,
    input  logic [DATA_WIDTH-1:0] i_direct_addr,
    output logic                  o_fetch_req,
    output logic [DATA_WIDTH-1:0] o_fetch_addr,
    output logic                  o_instr_valid,
    output logic [DATA_WIDTH-1:0] o_pc,
    output logic                  o_taken,
    output logic                  o_flush,
    output logic                  o_busy,
    output logic                  o_halted,
    output logic [CNT_WIDTH-1:0]  o_jump_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    state_t state;
    logic   operands_equal;

    assign operands_equal = (i_operand0 == i_operand1);
    assign o_fetch_addr   = o_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            o_pc          <= RESET_ADDR;
            o_fetch_req   <= 1'b0;
            o_instr_valid <= 1'b0;
            o_taken       <= 1'b0;
            o_flush       <= 1'b0;
            o_busy        <= 1'b0;
            o_halted      <= 1'b0;
            o_jump_count  <= '0;
        end else begin
            o_instr_valid <= 1'b0;
            o_taken       <= 1'b0;
            o_flush       <= 1'b0;
            case (state)
                IDLE, HALT: begin
                    if (i_start) begin
                        state       <= FETCH;
                        o_pc        <= RESET_ADDR;
                        o_fetch_req <= 1'b1;
                        o_busy      <= 1'b1;
                        o_halted    <= 1'b0;
                    end
                end
                FETCH: begin
                    if (o_fetch_req && i_fetch_ack) begin
                        state         <= ISSUE;
                        o_fetch_req   <= 1'b0;
                        o_instr_valid <= 1'b1;
                    end
                end
                ISSUE: begin
                    // Halt wins over everything presented in the same cycle.
                    if (i_halt) begin
                        state    <= HALT;
                        o_busy   <= 1'b0;
                        o_halted <= 1'b1;
                    end else if (i_jump_valid) begin
                        state       <= FETCH;
                        o_fetch_req <= 1'b1;
                        if (operands_equal) begin
                            o_pc    <= i_direct_addr;
                            o_taken <= 1'b1;
                            o_flush <= 1'b1;
                            if (o_jump_count != CNT_MAX) begin
                                o_jump_count <= o_jump_count + 1'b1;
                            end
                        end else begin
                            o_pc <= o_pc + 1'b1;
                        end
                    end else if (i_done) begin
                        state       <= FETCH;
                        o_fetch_req <= 1'b1;
                        o_pc        <= o_pc + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard bench for pc_sequencer (narrow counter so saturation is reachable)
module tb_pc_sequencer;

    localparam int DW = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_start = 1'b0;
    logic          i_halt = 1'b0;
    logic          i_fetch_ack = 1'b0;
    logic          i_done = 1'b0;
    logic          i_jump_valid = 1'b0;
    logic [DW-1:0] i_operand0 = '0;
    logic [DW-1:0] i_operand1 = '0;
    logic [DW-1:0] i_direct_addr = '0;
    logic          o_fetch_req;
    logic [DW-1:0] o_fetch_addr;
    logic          o_instr_valid;
    logic [DW-1:0] o_pc;
    logic          o_taken;
    logic          o_flush;
    logic          o_busy;
    logic          o_halted;
    logic [CW-1:0] o_jump_count;

    pc_sequencer #(.DATA_WIDTH(DW), .RESET_ADDR(8'h00), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_halt(i_halt),
        .i_fetch_ack(i_fetch_ack), .i_done(i_done), .i_jump_valid(i_jump_valid),
        .i_operand0(i_operand0), .i_operand1(i_operand1), .i_direct_addr(i_direct_addr),
        .o_fetch_req(o_fetch_req), .o_fetch_addr(o_fetch_addr), .o_instr_valid(o_instr_valid),
        .o_pc(o_pc), .o_taken(o_taken), .o_flush(o_flush), .o_busy(o_busy),
        .o_halted(o_halted), .o_jump_count(o_jump_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] pc;
        logic [CW-1:0] cnt;
    } taken_t;

    int            tests = 0;
    int            fails = 0;
    int            iv_count = 0;
    logic [CW-1:0] model_cnt = '0;
    logic [DW-1:0] fetch_q[$];
    taken_t        taken_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT completes a fetch or pulses o_taken.
    initial begin
        logic [DW-1:0] exp_addr;
        taken_t        exp_tk;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (o_fetch_req && i_fetch_ack) begin
                    if (fetch_q.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL fetch_unexpected: got addr 0x%0h, expected no fetch", o_fetch_addr);
                    end else begin
                        exp_addr = fetch_q.pop_front();
                        check("fetch_addr", 32'(o_fetch_addr), 32'(exp_addr));
                    end
                end
                if (o_instr_valid) iv_count++;
                if (o_taken) begin
                    if (taken_q.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL taken_unexpected: got o_taken=1 at pc 0x%0h, expected 0", o_pc);
                    end else begin
                        exp_tk = taken_q.pop_front();
                        check("taken_pc", 32'(o_pc), 32'(exp_tk.pc));
                        check("taken_count", 32'(o_jump_count), 32'(exp_tk.cnt));
                        check("taken_flush", 32'(o_flush), 32'd1);
                    end
                end else if (o_flush) begin
                    check("flush_without_taken", 32'(o_flush), 32'd0);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_fetch(input logic [DW-1:0] exp_addr, input int delay);
        int n = 0;
        fetch_q.push_back(exp_addr);
        while (!o_fetch_req && n < 20) begin
            tick();
            n++;
        end
        check("fetch_req_seen", 32'(o_fetch_req), 32'd1);
        repeat (delay) tick();
        i_fetch_ack = 1'b1;
        tick();
        i_fetch_ack = 1'b0;
        check("instr_valid", 32'(o_instr_valid), 32'd1);
    endtask

    task automatic issue_done();
        i_done = 1'b1;
        tick();
        i_done = 1'b0;
        check("done_to_req", 32'(o_fetch_req), 32'd1);
    endtask

    task automatic issue_jump(input logic [DW-1:0] op0, input logic [DW-1:0] op1,
                              input logic [DW-1:0] tgt, input logic with_done);
        if (op0 == op1) begin
            if (model_cnt != '1) model_cnt++;
            taken_q.push_back('{pc: tgt, cnt: model_cnt});
        end
        i_jump_valid = 1'b1; i_operand0 = op0; i_operand1 = op1;
        i_direct_addr = tgt; i_done = with_done;
        tick();
        i_jump_valid = 1'b0; i_done = 1'b0;
        check("jump_to_req", 32'(o_fetch_req), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_pc", 32'(o_pc), 32'h00);
        check("rst_count", 32'(o_jump_count), 32'd0);
        check("rst_outs", {26'd0, o_fetch_req, o_instr_valid, o_taken, o_flush, o_busy, o_halted}, 32'd0);
        rst_n = 1'b1;
        i_fetch_ack = 1'b1;
        repeat (2) tick();
        check("idle_ignores_ack", 32'(o_fetch_req), 32'd0);
        i_fetch_ack = 1'b0;

        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        check("start_req", 32'(o_fetch_req), 32'd1);
        check("start_busy", 32'(o_busy), 32'd1);

        // Sequential fetch 0..3
        for (int a = 0; a < 4; a++) begin
            do_fetch(DW'(a), 2);
            issue_done();
        end
        check("instr_valid_pulses", 32'(iv_count), 32'd4);

        // Taken / not-taken / jump+done to self
        do_fetch(8'h04, 0);
        issue_done();
        do_fetch(8'h05, 0);
        check("pc_before_jump", 32'(o_pc), 32'h05);
        issue_jump(8'h3C, 8'h3C, 8'h40, 1'b0);
        check("taken_now", 32'(o_taken), 32'd1);
        check("count_after_taken", 32'(o_jump_count), 32'd1);
        do_fetch(8'h40, 1);
        issue_jump(8'h3C, 8'h3D, 8'h99, 1'b0);
        check("not_taken_pc", 32'(o_pc), 32'h41);
        check("not_taken_count", 32'(o_jump_count), 32'd1);
        do_fetch(8'h41, 0);
        issue_jump(8'h5A, 8'h5A, 8'h41, 1'b1);
        check("jump_done_count", 32'(o_jump_count), 32'd2);
        do_fetch(8'h41, 0);

        // PC wrap
        issue_jump(8'h00, 8'h00, 8'hFF, 1'b0);
        do_fetch(8'hFF, 0);
        issue_done();
        check("pc_wrap", 32'(o_pc), 32'h00);
        do_fetch(8'h00, 0);
        issue_done();
        do_fetch(8'h01, 0);

        // Start ignored in ISSUE, then halt beats a simultaneous taken jump
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        check("issue_ignores_start", {30'd0, o_busy, o_fetch_req}, 32'd2);
        i_halt = 1'b1; i_jump_valid = 1'b1; i_done = 1'b1;
        i_operand0 = 8'h11; i_operand1 = 8'h11; i_direct_addr = 8'h77;
        tick();
        i_halt = 1'b0; i_jump_valid = 1'b0; i_done = 1'b0;
        check("halt_state", {29'd0, o_halted, o_busy, o_fetch_req}, 32'd4);
        check("halt_pc", 32'(o_pc), 32'h01);
        check("halt_count", 32'(o_jump_count), 32'd3);
        repeat (2) tick();
        check("halt_frozen_pc", 32'(o_pc), 32'h01);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        check("restart_pc", 32'(o_pc), 32'h00);
        check("restart_flags", {29'd0, o_halted, o_busy, o_fetch_req}, 32'd3);
        check("restart_count_kept", 32'(o_jump_count), 32'd3);
        do_fetch(8'h00, 1);

        // Counter saturation
        for (int k = 0; k < 14; k++) begin
            issue_jump(DW'(8'h10 + k), DW'(8'h10 + k), DW'(8'h20 + k), 1'b0);
            do_fetch(DW'(8'h20 + k), 0);
        end
        check("count_saturated", 32'(o_jump_count), 32'hF);

        // Async reset with an ack pending
        issue_done();
        check("pre_reset_req", 32'(o_fetch_req), 32'd1);
        #1;
        rst_n = 1'b0;
        i_fetch_ack = 1'b1;
        #1;
        check("async_rst_req", 32'(o_fetch_req), 32'd0);
        check("async_rst_pc", 32'(o_pc), 32'h00);
        check("async_rst_count", 32'(o_jump_count), 32'd0);
        check("async_rst_busy", 32'(o_busy), 32'd0);
        model_cnt = '0;
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        i_fetch_ack = 1'b0;
        check("post_rst_idle", {29'd0, o_busy, o_fetch_req, o_instr_valid}, 32'd0);

        check("fetch_q_drained", 32'(fetch_q.size()), 32'd0);
        check("taken_q_drained", 32'(taken_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
